// File: rtl/adpll_loop_sequencer.sv
// rtl/adpll_loop_sequencer.sv - ADPLL phase counter and multi-cycle PI loop filter driving the DCO control word
module adpll_loop_sequencer #(
  parameter int                ERR_W      = 16,
  parameter int                CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] CTRL_INIT  = 16'h8000,
  parameter int                KP_SHIFT   = 2,
  parameter int                KI_SHIFT   = 4,
  parameter int                LOCK_TOL   = 4,
  parameter int                LOCK_COUNT = 8
) (
  input  logic              fpga_clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              lead_i,
  input  logic              save_and_clear_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              ctrl_valid_o,
  output logic              locked_o,
  output logic              busy_o,
  output logic              sat_o,
  output logic              missed_o
);

  localparam int IW     = CTRL_W + 2;
  localparam int LCNT_W = $clog2(LOCK_COUNT + 1);

  localparam logic [ERR_W-1:0]        CNT_MAX   = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic signed [IW-1:0]    INTEG_MAX = (IW'(1) <<< (CTRL_W-1)) - IW'(1);
  localparam logic signed [IW-1:0]    INTEG_MIN = -(IW'(1) <<< (CTRL_W-1));
  localparam logic signed [IW-1:0]    CTRL_MAX  = $signed({2'b00, {CTRL_W{1'b1}}});
  localparam logic signed [ERR_W-1:0] TOL_HI    = ERR_W'(LOCK_TOL);
  localparam logic signed [ERR_W-1:0] TOL_LO    = -TOL_HI;
  localparam logic [LCNT_W-1:0]       LCNT_MAX  = LCNT_W'(LOCK_COUNT);

  typedef enum logic [2:0] {IDLE, PROP, INTEG, SUM, UPDATE} state_t;

  state_t                    state_q, state_d;
  logic [ERR_W-1:0]          cnt_q, cnt_d;
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic signed [ERR_W-1:0]   p_q, p_d;
  logic signed [CTRL_W:0]    integ_q, integ_d;
  logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
  logic                      valid_q, valid_d;
  logic                      sat_q, sat_d;
  logic                      locked_q, locked_d;
  logic                      busy_q, busy_d;
  logic                      missed_q, missed_d;
  logic [LCNT_W-1:0]         lcnt_q, lcnt_d;

  logic signed [IW-1:0]      integ_sum;
  logic signed [IW-1:0]      sum_full;
  logic                      in_tol;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    p_d       = p_q;
    integ_d   = integ_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    sat_d     = 1'b0;
    locked_d  = locked_q;
    lcnt_d    = lcnt_q;
    missed_d  = save_and_clear_i && (state_q != IDLE);
    integ_sum = IW'(integ_q) + IW'(err_q >>> KI_SHIFT);
    sum_full  = $signed({2'b00, CTRL_INIT}) + IW'(integ_q) + IW'(p_q);
    in_tol    = (err_q <= TOL_HI) && (err_q >= TOL_LO);

    if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end

    case (state_q)
      IDLE: begin
        // Capture the pre-increment count; the clear wins over a same-cycle enable
        if (save_and_clear_i) begin
          err_d   = lead_i ? $signed(cnt_q) : -$signed(cnt_q);
          cnt_d   = '0;
          state_d = PROP;
        end
      end
      PROP: begin
        p_d     = err_q >>> KP_SHIFT;
        state_d = INTEG;
      end
      INTEG: begin
        if (integ_sum > INTEG_MAX) begin
          integ_d = INTEG_MAX[CTRL_W:0];
        end else if (integ_sum < INTEG_MIN) begin
          integ_d = INTEG_MIN[CTRL_W:0];
        end else begin
          integ_d = integ_sum[CTRL_W:0];
        end
        state_d = SUM;
      end
      SUM: begin
        // Results are registered here so they are visible during the UPDATE cycle
        valid_d = 1'b1;
        if (sum_full[IW-1]) begin
          ctrl_d = '0;
          sat_d  = 1'b1;
        end else if (sum_full > CTRL_MAX) begin
          ctrl_d = '1;
          sat_d  = 1'b1;
        end else begin
          ctrl_d = sum_full[CTRL_W-1:0];
        end
        if (in_tol) begin
          if (lcnt_q != LCNT_MAX) begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
          locked_d = (lcnt_d == LCNT_MAX);
        end else begin
          lcnt_d   = '0;
          locked_d = 1'b0;
        end
        state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= '0;
      p_q      <= '0;
      integ_q  <= '0;
      ctrl_q   <= CTRL_INIT;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      p_q      <= p_d;
      integ_q  <= integ_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
      lcnt_q   <= lcnt_d;
    end
  end

  assign ctrl_o       = ctrl_q;
  assign ctrl_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign busy_o       = busy_q;
  assign sat_o        = sat_q;
  assign missed_o     = missed_q;

endmodule

// File: tb/tb_adpll_loop_sequencer.sv
// tb/tb_adpll_loop_sequencer.sv - scoreboard bench for the ADPLL loop sequencer (default gains and unity gains)
module tb_adpll_loop_sequencer;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic enable_i = 1'b0;
  logic lead_i = 1'b0;
  logic save_and_clear_i = 1'b0;

  logic [15:0] ctrl0, ctrl1;
  logic v0, v1, lk0, lk1, bz0, bz1, st0, st1, ms0, ms1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    int ctrl;
    bit sat;
    bit locked;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int m_integ[2];
  int m_lcnt[2];
  int kp_s[2] = '{2, 0};
  int ki_s[2] = '{4, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adpll_loop_sequencer dut0 (
    .fpga_clk_i       (clk),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .lead_i           (lead_i),
    .save_and_clear_i (save_and_clear_i),
    .ctrl_o           (ctrl0),
    .ctrl_valid_o     (v0),
    .locked_o         (lk0),
    .busy_o           (bz0),
    .sat_o            (st0),
    .missed_o         (ms0)
  );

  adpll_loop_sequencer #(.KP_SHIFT(0), .KI_SHIFT(0)) dut1 (
    .fpga_clk_i       (clk),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .lead_i           (lead_i),
    .save_and_clear_i (save_and_clear_i),
    .ctrl_o           (ctrl1),
    .ctrl_valid_o     (v1),
    .locked_o         (lk1),
    .busy_o           (bz1),
    .sat_o            (st1),
    .missed_o         (ms1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_integ[i] = 0;
      m_lcnt[i]  = 0;
    end
  endtask

  task automatic push_exp(input int n, input bit lead);
    int   mag, err, p, s;
    exp_t e;
    mag = (n > 32767) ? 32767 : n;
    err = lead ? mag : -mag;
    for (int i = 0; i < 2; i++) begin
      p = err >>> kp_s[i];
      m_integ[i] = m_integ[i] + (err >>> ki_s[i]);
      if (m_integ[i] > 32767)  m_integ[i] = 32767;
      if (m_integ[i] < -32768) m_integ[i] = -32768;
      s = 32768 + m_integ[i] + p;
      e.cyc = cyc + 4;
      e.sat = (s < 0) || (s > 65535);
      e.ctrl = (s < 0) ? 0 : ((s > 65535) ? 65535 : s);
      if (err <= 4 && err >= -4) begin
        if (m_lcnt[i] < 8) m_lcnt[i]++;
      end else begin
        m_lcnt[i] = 0;
      end
      e.locked = (m_lcnt[i] == 8);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (q0.size() != 0 || q1.size() != 0); i++) step();
    chk("drain", q0.size() + q1.size(), 0);
    step();
  endtask

  task automatic measure(input int n, input bit lead, input bit keep_en);
    enable_i = 1'b1;
    repeat (n) step();
    enable_i = keep_en;
    lead_i = lead;
    save_and_clear_i = 1'b1;
    push_exp(n, lead);
    step();
    enable_i = 1'b0;
    save_and_clear_i = 1'b0;
    drain();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (v0) begin
      if (q0.size() == 0) chk("unexp_valid0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("lat0", cyc, e.cyc);
        chk("ctrl0", ctrl0, e.ctrl);
        chk("sat0", st0, e.sat);
        chk("lock0", lk0, e.locked);
      end
    end else if (st0) chk("sat0_nopulse", st0, 0);
    if (v1) begin
      if (q1.size() == 0) chk("unexp_valid1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("lat1", cyc, e.cyc);
        chk("ctrl1", ctrl1, e.ctrl);
        chk("sat1", st1, e.sat);
        chk("lock1", lk1, e.locked);
      end
    end else if (st1) chk("sat1_nopulse", st1, 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    step();
    step();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_ctrl0", ctrl0, 16'h8000);
    chk("rst_ctrl1", ctrl1, 16'h8000);
    chk("rst_valid", v0, 0);
    chk("rst_locked", lk0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_sat", st0, 0);
    chk("rst_missed", ms0, 0);
    repeat (10) step();
    chk("idle_ctrl0", ctrl0, 16'h8000);

    measure(20, 1'b1, 1'b0);
    do_reset();
    measure(20, 1'b0, 1'b0);
    measure(12, 1'b1, 1'b1);
    measure(5, 1'b1, 1'b0);

    // dropped pulse: save at N and N+2
    do_reset();
    enable_i = 1'b1;
    repeat (8) step();
    enable_i = 1'b0;
    lead_i = 1'b1;
    save_and_clear_i = 1'b1;
    push_exp(8, 1'b1);
    step();
    save_and_clear_i = 1'b0;
    @(negedge clk);
    chk("busy_n1", bz0, 1);
    step();
    save_and_clear_i = 1'b1;
    step();
    save_and_clear_i = 1'b0;
    @(negedge clk);
    chk("missed_n3", ms0, 1);
    chk("missed1_n3", ms1, 1);
    step();
    @(negedge clk);
    chk("missed_n4", ms0, 0);
    drain();
    chk("busy_idle", bz0, 0);

    // reset in the middle of a computation
    enable_i = 1'b1;
    repeat (6) step();
    enable_i = 1'b0;
    lead_i = 1'b1;
    save_and_clear_i = 1'b1;
    step();
    save_and_clear_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    model_reset();
    repeat (6) step();
    @(negedge clk);
    chk("midrst_ctrl0", ctrl0, 16'h8000);
    chk("midrst_ctrl1", ctrl1, 16'h8000);
    chk("midrst_busy", bz0, 0);

    // lock acquisition and loss
    do_reset();
    for (int i = 0; i < 8; i++) measure(3, 1'b1, 1'b0);
    chk("locked_hold", lk0, 1);
    measure(10, 1'b1, 1'b0);
    chk("unlocked_hold", lk0, 0);

    // counter saturation and output clamping
    do_reset();
    measure(34000, 1'b1, 1'b0);
    do_reset();
    measure(16400, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
